// File: rtl/display_flag_sequencer.sv
// display_flag_sequencer: round-robin scheduler driving the display `flag` mode select with fixed dwell/gap timing.
// Optional macro AUTO_CYCLE_EN: with no requests, idle behaves as if req[rr_ptr] were asserted (free-running cycle).
module display_flag_sequencer #(
    parameter int DWELL_CYCLES = 100,
    parameter int GAP_CYCLES   = 100,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       abort,
    output logic [2:0] flag,
    output logic [2:0] grant,
    output logic       busy,
    output logic       mode_done
);
    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic [1:0] rr_ptr, p1, p2, sel, sel_nxt;
    logic [2:0] eff_req;
`ifdef AUTO_CYCLE_EN
    assign eff_req = (req != 3'b000) ? req : 3'b001 << rr_ptr;
`else
    assign eff_req = req;
`endif
    // Search order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3); the last candidate is the fallback.
    always_comb begin
        p1 = (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
        p2 = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
        sel = eff_req[rr_ptr] ? rr_ptr : eff_req[p1] ? p1 : p2;
        sel_nxt = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            flag <= 3'd0;
            grant <= 3'd0;
            busy <= 1'b0;
            mode_done <= 1'b0;
            cnt <= '0;
            rr_ptr <= 2'd0;
        end else begin
            mode_done <= 1'b0;
            case (state)
                IDLE: if (eff_req != 3'b000) begin
                    state <= ACTIVE;
                    flag <= {1'b0, sel} + 3'd1;
                    grant <= 3'b001 << sel;
                    busy <= 1'b1;
                    cnt <= DWELL_LOAD;
                    rr_ptr <= sel_nxt;
                end
                ACTIVE: if (abort || cnt == '0) begin
                    mode_done <= !abort;
                    flag <= 3'd0;
                    grant <= 3'd0;
                    state <= (GAP_CYCLES > 0) ? GAP : IDLE;
                    busy <= (GAP_CYCLES > 0);
                    cnt <= GAP_LOAD;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
                GAP: if (cnt == '0) begin
                    state <= IDLE;
                    busy <= 1'b0;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_display_flag_sequencer.sv
// tb_display_flag_sequencer: scoreboard bench; a plan-queue reference model predicts every cycle's outputs.
module tb_display_flag_sequencer;
    localparam int DWELL = 4;
    localparam int GAPC = 2;
    typedef struct packed {
        logic [2:0] flag;
        logic [2:0] grant;
        logic       busy;
        logic       md;
    } ent_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] req = 3'b000;
    logic abort = 1'b0;
    logic [2:0] flag, grant;
    logic busy, mode_done;
    int n_chk = 0;
    int n_fail = 0;
    ent_t exp_q[$];
    ent_t plan[$];
    ent_t cur;
    int rr;

    display_flag_sequencer #(.DWELL_CYCLES(DWELL), .GAP_CYCLES(GAPC), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .abort(abort),
        .flag(flag), .grant(grant), .busy(busy), .mode_done(mode_done)
    );

    always #5 clk = ~clk;

    // Model: a granted request expands into a plan of future cycles (dwell, then gap); idle cycles arbitrate.
    always @(posedge clk or negedge rst_n) begin
        ent_t nx, t;
        logic [2:0] r;
        int found;
        if (!rst_n) begin
            cur = '0;
            plan.delete();
            rr = 0;
            exp_q.delete();
            exp_q.push_back('0);
        end else begin
            if (cur.flag != 3'd0 && abort) begin
                while (plan.size() > 0 && plan[0].flag != 3'd0) void'(plan.pop_front());
                t = plan.pop_front();
                t.md = 1'b0;
                plan.push_front(t);
            end
            nx = '0;
            if (plan.size() > 0) begin
                nx = plan.pop_front();
            end else if (!cur.busy) begin
                r = req;
`ifdef AUTO_CYCLE_EN
                if (r == 3'b000) r[rr] = 1'b1;
`endif
                found = -1;
                for (int k = 0; k < 3; k++)
                    if (found < 0 && r[(rr + k) % 3]) found = (rr + k) % 3;
                if (found >= 0) begin
                    rr = (found + 1) % 3;
                    for (int k = 0; k < DWELL; k++) plan.push_back({3'(found + 1), 3'(1 << found), 1'b1, 1'b0});
                    if (GAPC > 0) begin
                        plan.push_back({3'd0, 3'd0, 1'b1, 1'b1});
                        for (int k = 1; k < GAPC; k++) plan.push_back({3'd0, 3'd0, 1'b1, 1'b0});
                    end else begin
                        plan.push_back({3'd0, 3'd0, 1'b0, 1'b1});
                    end
                    nx = plan.pop_front();
                end
            end
            cur = nx;
            exp_q.push_back(nx);
        end
    end

    always @(negedge clk) begin
        ent_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if ({flag, grant, busy, mode_done} !== e) begin
                n_fail++;
                $display("FAIL outputs t=%0t: got flag=%0d grant=%b busy=%b done=%b, want flag=%0d grant=%b busy=%b done=%b",
                         $time, flag, grant, busy, mode_done, e.flag, e.grant, e.busy, e.md);
            end
        end
    end

    task automatic cyc(input logic [2:0] r, input logic a);
        req = r;
        abort = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) cyc(3'b000, 1'b0);
        repeat (20) cyc(3'b010, 1'b0);
        repeat (8) cyc(3'b000, 1'b0);
        repeat (30) cyc(3'b111, 1'b0);
        repeat (8) cyc(3'b000, 1'b0);
        cyc(3'b001, 1'b0);
        cyc(3'b001, 1'b0);
        cyc(3'b000, 1'b1);
        repeat (4) cyc(3'b000, 1'b0);
        repeat (10) cyc(3'b011, 1'b0);
        repeat (10) cyc(3'b000, 1'b0);
        cyc(3'b100, 1'b0);
        cyc(3'b100, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (flag !== 3'd0 || grant !== 3'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got flag=%0d grant=%b busy=%b, want 0 000 0", flag, grant, busy);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) cyc(3'b111, 1'b0);
        repeat (2000) cyc(3'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0));
        repeat (10) cyc(3'b000, 1'b0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
